// File: rtl/color_profile_sched_if.sv
// Host/tracker-facing bundle for color_profile_sched: config writes, tracker hits, active thresholds, per-frame results.
// No backpressure anywhere on this bundle; every signal is sampled or presented each cycle.
interface color_profile_sched_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_PROFILES = 4,
  parameter int CNT_WIDTH    = 19
);
  localparam int PW = $clog2(NUM_PROFILES);

  logic                  frame_start;
  logic                  cfg_we;
  logic [PW-1:0]         cfg_sel;
  logic [2:0]            cfg_field;
  logic [DATA_WIDTH-1:0] cfg_wdata;
  logic                  pix_valid;
  logic                  pix_hit;

  logic [DATA_WIDTH-1:0] h_min, h_max, h_min2, h_max2, s_min, v_min, v_max;
  logic                  thr_valid;
  logic [PW-1:0]         active_id;
  logic                  result_valid;
  logic [PW-1:0]         result_id;
  logic [CNT_WIDTH-1:0]  result_count;

  modport master (
    output frame_start, cfg_we, cfg_sel, cfg_field, cfg_wdata, pix_valid, pix_hit,
    input  h_min, h_max, h_min2, h_max2, s_min, v_min, v_max, thr_valid, active_id,
    input  result_valid, result_id, result_count
  );

  modport slave (
    input  frame_start, cfg_we, cfg_sel, cfg_field, cfg_wdata, pix_valid, pix_hit,
    output h_min, h_max, h_min2, h_max2, s_min, v_min, v_max, thr_valid, active_id,
    output result_valid, result_id, result_count
  );
endinterface

// File: rtl/color_profile_sched.sv
// Round-robins one color tracker over the enabled threshold profiles, one per frame; result appears FLUSH_CYCLES+2 cycles after frame_start.
// No backpressure: config writes, hits and frame_start are accepted every cycle, and results are single-cycle pulses.
module color_profile_sched #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_PROFILES = 4,
  parameter int CNT_WIDTH    = 19,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  color_profile_sched_if.slave   bus
);
  localparam int PW = $clog2(NUM_PROFILES);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] h_min;
    logic [DATA_WIDTH-1:0] h_max;
    logic [DATA_WIDTH-1:0] h_min2;
    logic [DATA_WIDTH-1:0] h_max2;
    logic [DATA_WIDTH-1:0] s_min;
    logic [DATA_WIDTH-1:0] v_min;
    logic [DATA_WIDTH-1:0] v_max;
  } thr_t;

  localparam thr_t THR_RST = '{DATA_WIDTH'(0), DATA_WIDTH'(6), DATA_WIDTH'(249), DATA_WIDTH'(255),
                               DATA_WIDTH'(151), DATA_WIDTH'(50), DATA_WIDTH'(200)};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWITCH} state_t;

  thr_t                  shadow [NUM_PROFILES];
  logic [NUM_PROFILES-1:0] shadow_en;

  state_t                state;
  thr_t                  active;
  logic                  thr_valid;
  logic [PW-1:0]         act_id;
  logic                  res_valid;
  logic [PW-1:0]         res_id;
  logic [CNT_WIDTH-1:0]  res_count;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [FW-1:0]         drain_cnt;
  logic                  from_idle;

  logic                  hit;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [PW-1:0]         search_base;
  logic [PW-1:0]         idx;
  logic [PW-1:0]         next_id;
  logic                  next_found;

  // Shadow bank is written every cycle regardless of scheduler state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROFILES; i++) begin
        shadow[i] <= THR_RST;
      end
      shadow_en <= NUM_PROFILES'(1);
    end else if (bus.cfg_we) begin
      case (bus.cfg_field)
        3'd0:    shadow[bus.cfg_sel].h_min  <= bus.cfg_wdata;
        3'd1:    shadow[bus.cfg_sel].h_max  <= bus.cfg_wdata;
        3'd2:    shadow[bus.cfg_sel].h_min2 <= bus.cfg_wdata;
        3'd3:    shadow[bus.cfg_sel].h_max2 <= bus.cfg_wdata;
        3'd4:    shadow[bus.cfg_sel].s_min  <= bus.cfg_wdata;
        3'd5:    shadow[bus.cfg_sel].v_min  <= bus.cfg_wdata;
        3'd6:    shadow[bus.cfg_sel].v_max  <= bus.cfg_wdata;
        default: shadow_en[bus.cfg_sel]     <= bus.cfg_wdata[0];
      endcase
    end
  end

  assign hit      = bus.pix_valid && bus.pix_hit;
  assign cnt_next = (hit && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;

  // First enabled profile at or after search_base, wrapping; current profile is the last candidate.
  always_comb begin
    search_base = from_idle ? '0 : act_id + PW'(1);
    idx         = '0;
    next_id     = act_id;
    next_found  = 1'b0;
    for (int i = 0; i < NUM_PROFILES; i++) begin
      idx = search_base + PW'(i);
      if (!next_found && shadow_en[idx]) begin
        next_id    = idx;
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      active    <= '0;
      thr_valid <= 1'b0;
      act_id    <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      from_idle <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start && (|shadow_en)) begin
            state     <= SWITCH;
            from_idle <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt_next;
          if (bus.frame_start) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt_next;
          if (drain_cnt == FW'(FLUSH_CYCLES - 1)) begin
            state <= SWITCH;
          end else begin
            drain_cnt <= drain_cnt + FW'(1);
          end
        end
        SWITCH: begin
          if (!from_idle) begin
            res_valid <= 1'b1;
            res_id    <= act_id;
            res_count <= cnt_next;
          end
          cnt       <= '0;
          from_idle <= 1'b0;
          if (next_found) begin
            active    <= shadow[next_id];
            act_id    <= next_id;
            thr_valid <= 1'b1;
            state     <= RUN;
          end else begin
            thr_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.h_min        = active.h_min;
  assign bus.h_max        = active.h_max;
  assign bus.h_min2       = active.h_min2;
  assign bus.h_max2       = active.h_max2;
  assign bus.s_min        = active.s_min;
  assign bus.v_min        = active.v_min;
  assign bus.v_max        = active.v_max;
  assign bus.thr_valid    = thr_valid;
  assign bus.active_id    = act_id;
  assign bus.result_valid = res_valid;
  assign bus.result_id    = res_id;
  assign bus.result_count = res_count;
endmodule

// File: tb/tb_color_profile_sched.sv
// Directed bench for color_profile_sched: default instance plus a CNT_WIDTH=3 instance for saturation.
module tb_color_profile_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  color_profile_sched_if #(.DATA_WIDTH(8), .NUM_PROFILES(4), .CNT_WIDTH(19)) b ();
  color_profile_sched_if #(.DATA_WIDTH(8), .NUM_PROFILES(4), .CNT_WIDTH(3))  b3 ();

  color_profile_sched #(.DATA_WIDTH(8), .NUM_PROFILES(4), .CNT_WIDTH(19), .FLUSH_CYCLES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  color_profile_sched #(.DATA_WIDTH(8), .NUM_PROFILES(4), .CNT_WIDTH(3), .FLUSH_CYCLES(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  logic        got;
  logic [1:0]  rid;
  logic [18:0] rcnt;
  logic [1:0]  raid;
  logic [7:0]  rsmin;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    b.frame_start = 0; b.cfg_we = 0; b.cfg_sel = 0; b.cfg_field = 0; b.cfg_wdata = 0;
    b.pix_valid = 0; b.pix_hit = 0;
    b3.frame_start = 0; b3.cfg_we = 0; b3.cfg_sel = 0; b3.cfg_field = 0; b3.cfg_wdata = 0;
    b3.pix_valid = 0; b3.pix_hit = 0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [2:0] field, input logic [7:0] data);
    b.cfg_we = 1; b.cfg_sel = sel; b.cfg_field = field; b.cfg_wdata = data;
    tick;
    b.cfg_we = 0;
  endtask

  // Drives nhits spaced hits, then frame_start, and captures the result pulse within a bounded window.
  task automatic do_frame(input int nhits, output logic g, output logic [1:0] id, output logic [18:0] cnt,
                          output logic [1:0] aid, output logic [7:0] smin);
    for (int i = 0; i < nhits; i++) begin
      b.pix_valid = 1; b.pix_hit = 1;
      tick;
      b.pix_valid = 0; b.pix_hit = 0;
      tick;
    end
    b.frame_start = 1;
    tick;
    b.frame_start = 0;
    g = 0; id = 0; cnt = 0; aid = 0; smin = 0;
    for (int k = 0; k < 12 && !g; k++) begin
      if (b.result_valid) begin
        g = 1; id = b.result_id; cnt = b.result_count; aid = b.active_id; smin = b.s_min;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    idle_inputs;
    rst_n = 0;
    tick;
    tests_run++;
    if ({b.h_min, b.h_max, b.h_min2, b.h_max2, b.s_min, b.v_min, b.v_max} !== 56'd0) begin
      fails++; $display("FAIL reset_thresholds: got %h expected 0", {b.h_min, b.h_max, b.h_min2, b.h_max2, b.s_min, b.v_min, b.v_max});
    end
    tests_run++;
    if ({b.thr_valid, b.active_id, b.result_valid, b.result_id} !== 6'd0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0", {b.thr_valid, b.active_id, b.result_valid, b.result_id});
    end
    tests_run++;
    if ({b.result_count, b3.result_count} !== 22'd0) begin
      fails++; $display("FAIL reset_count: got %0d/%0d expected 0/0", b.result_count, b3.result_count);
    end
    rst_n = 1;
    tick;
  endtask

  task automatic test_first_frame;
    b.frame_start = 1;
    tick;
    b.frame_start = 0;
    tests_run++;
    if ({b.thr_valid, b.result_valid} !== 2'b00) begin
      fails++; $display("FAIL first_cycle1: got thr_valid=%b result_valid=%b expected 0 0", b.thr_valid, b.result_valid);
    end
    tick;
    tests_run++;
    if ({b.thr_valid, b.active_id, b.result_valid} !== {1'b1, 2'd0, 1'b0}) begin
      fails++; $display("FAIL first_cycle2_ctrl: got thr_valid=%b id=%0d rv=%b expected 1 0 0", b.thr_valid, b.active_id, b.result_valid);
    end
    tests_run++;
    if ({b.h_min, b.h_max, b.h_min2, b.h_max2, b.s_min, b.v_min, b.v_max} !==
        {8'd0, 8'd6, 8'd249, 8'd255, 8'd151, 8'd50, 8'd200}) begin
      fails++; $display("FAIL first_thresholds: got %h expected 0006f9ff9732c8", {b.h_min, b.h_max, b.h_min2, b.h_max2, b.s_min, b.v_min, b.v_max});
    end
  endtask

  task automatic test_single_profile;
    for (int i = 0; i < 5; i++) begin
      b.pix_valid = 1; b.pix_hit = 1;
      tick;
    end
    b.pix_valid = 1; b.pix_hit = 0; tick;
    b.pix_valid = 0; b.pix_hit = 1; tick;
    b.pix_hit = 0;
    b.frame_start = 1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      b.frame_start = 0;
      b.pix_valid = (c == 2); b.pix_hit = (c == 2);
      tests_run++;
      if (b.result_valid !== (c == 5)) begin
        fails++; $display("FAIL single_pulse_c%0d: got %b expected %b", c, b.result_valid, (c == 5));
      end
      if (c == 5) begin
        tests_run++;
        if ({b.result_id, b.result_count, b.active_id, b.thr_valid} !== {2'd0, 19'd6, 2'd0, 1'b1}) begin
          fails++; $display("FAIL single_result: got id=%0d cnt=%0d aid=%0d tv=%b expected 0 6 0 1", b.result_id, b.result_count, b.active_id, b.thr_valid);
        end
      end
    end
    tests_run++;
    if (b.result_count !== 19'd6) begin
      fails++; $display("FAIL single_hold: got %0d expected 6", b.result_count);
    end
  endtask

  task automatic test_round_robin;
    cfg_write(2, 7, 1);
    cfg_write(1, 7, 0);
    cfg_write(3, 7, 0);
    do_frame(3, got, rid, rcnt, raid, rsmin);
    tests_run++;
    if ({got, rid, rcnt, raid, rsmin} !== {1'b1, 2'd0, 19'd3, 2'd2, 8'd151}) begin
      fails++; $display("FAIL rr_frame1: got v=%b id=%0d cnt=%0d aid=%0d smin=%0d expected 1 0 3 2 151", got, rid, rcnt, raid, rsmin);
    end
    cfg_write(2, 4, 200);
    tests_run++;
    if (b.s_min !== 8'd151) begin
      fails++; $display("FAIL rr_midframe_smin: got %0d expected 151", b.s_min);
    end
    do_frame(0, got, rid, rcnt, raid, rsmin);
    tests_run++;
    if ({got, rid, rcnt, raid, rsmin} !== {1'b1, 2'd2, 19'd0, 2'd0, 8'd151}) begin
      fails++; $display("FAIL rr_frame2: got v=%b id=%0d cnt=%0d aid=%0d smin=%0d expected 1 2 0 0 151", got, rid, rcnt, raid, rsmin);
    end
    do_frame(7, got, rid, rcnt, raid, rsmin);
    tests_run++;
    if ({got, rid, rcnt, raid, rsmin} !== {1'b1, 2'd0, 19'd7, 2'd2, 8'd200}) begin
      fails++; $display("FAIL rr_frame3: got v=%b id=%0d cnt=%0d aid=%0d smin=%0d expected 1 0 7 2 200", got, rid, rcnt, raid, rsmin);
    end
    do_frame(1, got, rid, rcnt, raid, rsmin);
    tests_run++;
    if ({got, rid, rcnt, raid, rsmin} !== {1'b1, 2'd2, 19'd1, 2'd0, 8'd151}) begin
      fails++; $display("FAIL rr_frame4: got v=%b id=%0d cnt=%0d aid=%0d smin=%0d expected 1 2 1 0 151", got, rid, rcnt, raid, rsmin);
    end
  endtask

  task automatic test_switch_write;
    int seen;
    cfg_write(2, 7, 0);
    b.frame_start = 1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      b.frame_start = 0;
      b.cfg_we = (c == 4); b.cfg_sel = 0; b.cfg_field = 7; b.cfg_wdata = 0;
      if (c == 5) begin
        tests_run++;
        if ({b.result_valid, b.active_id, b.thr_valid} !== {1'b1, 2'd0, 1'b1}) begin
          fails++; $display("FAIL switch_write_sel: got rv=%b aid=%0d tv=%b expected 1 0 1", b.result_valid, b.active_id, b.thr_valid);
        end
      end
    end
    do_frame(2, got, rid, rcnt, raid, rsmin);
    tests_run++;
    if ({got, rid, rcnt} !== {1'b1, 2'd0, 19'd2}) begin
      fails++; $display("FAIL final_result: got v=%b id=%0d cnt=%0d expected 1 0 2", got, rid, rcnt);
    end
    tests_run++;
    if ({b.thr_valid, b.active_id, b.h_max} !== {1'b0, 2'd0, 8'd6}) begin
      fails++; $display("FAIL idle_hold: got tv=%b aid=%0d h_max=%0d expected 0 0 6", b.thr_valid, b.active_id, b.h_max);
    end
    seen = 0;
    for (int f = 0; f < 2; f++) begin
      b.frame_start = 1; b.pix_valid = 1; b.pix_hit = 1;
      for (int k = 0; k < 8; k++) begin
        tick;
        b.frame_start = 0;
        if (b.result_valid || b.thr_valid) seen++;
      end
    end
    b.pix_valid = 0; b.pix_hit = 0;
    tests_run++;
    if (seen !== 0) begin
      fails++; $display("FAIL idle_quiet: got %0d active cycles expected 0", seen);
    end
    cfg_write(1, 0, 10);
    cfg_write(1, 7, 1);
    cfg_write(0, 7, 1);
    b.frame_start = 1;
    tick;
    b.frame_start = 0;
    tick;
    tests_run++;
    if ({b.thr_valid, b.active_id, b.h_min, b.result_valid} !== {1'b1, 2'd0, 8'd0, 1'b0}) begin
      fails++; $display("FAIL restart_from_idle: got tv=%b aid=%0d h_min=%0d rv=%b expected 1 0 0 0", b.thr_valid, b.active_id, b.h_min, b.result_valid);
    end
    do_frame(2, got, rid, rcnt, raid, rsmin);
    tests_run++;
    if ({got, rid, rcnt, raid, b.h_min} !== {1'b1, 2'd0, 19'd2, 2'd1, 8'd10}) begin
      fails++; $display("FAIL restart_next: got v=%b id=%0d cnt=%0d aid=%0d h_min=%0d expected 1 0 2 1 10", got, rid, rcnt, raid, b.h_min);
    end
  endtask

  task automatic test_saturate;
    logic       g3;
    logic [2:0] c3;
    b3.frame_start = 1;
    tick;
    b3.frame_start = 0;
    tick;
    tests_run++;
    if (b3.thr_valid !== 1'b1) begin
      fails++; $display("FAIL sat_start: got thr_valid=%b expected 1", b3.thr_valid);
    end
    b3.pix_valid = 1; b3.pix_hit = 1;
    for (int i = 0; i < 12; i++) tick;
    b3.pix_valid = 0; b3.pix_hit = 0;
    b3.frame_start = 1;
    tick;
    b3.frame_start = 0;
    g3 = 0; c3 = 0;
    for (int k = 0; k < 12 && !g3; k++) begin
      if (b3.result_valid) begin g3 = 1; c3 = b3.result_count; end
      tick;
    end
    tests_run++;
    if ({g3, c3} !== {1'b1, 3'd7}) begin
      fails++; $display("FAIL sat_count: got v=%b cnt=%0d expected 1 7", g3, c3);
    end
  endtask

  task automatic test_drain_fs;
    int pulses;
    logic at5;
    pulses = 0; at5 = 0;
    b.frame_start = 1;
    for (int c = 1; c <= 14; c++) begin
      tick;
      b.frame_start = (c == 2 || c == 4);
      b.pix_valid = (c == 1); b.pix_hit = (c == 1);
      if (b.result_valid) begin
        pulses++;
        if (c == 5) at5 = 1;
      end
    end
    tests_run++;
    if ({pulses == 1, at5} !== 2'b11) begin
      fails++; $display("FAIL drain_fs_pulses: got %0d pulses at5=%b expected 1 1", pulses, at5);
    end
    tests_run++;
    if ({b.result_id, b.result_count, b.active_id} !== {2'd1, 19'd1, 2'd0}) begin
      fails++; $display("FAIL drain_fs_result: got id=%0d cnt=%0d aid=%0d expected 1 1 0", b.result_id, b.result_count, b.active_id);
    end
  endtask

  task automatic test_reset_drain;
    int seen;
    b.frame_start = 1;
    tick;
    b.frame_start = 0;
    tick;
    #2 rst_n = 0;
    #1;
    tests_run++;
    if ({b.h_min, b.h_max, b.h_min2, b.h_max2, b.s_min, b.v_min, b.v_max} !== 56'd0) begin
      fails++; $display("FAIL rst_drain_thr: got %h expected 0", {b.h_min, b.h_max, b.h_min2, b.h_max2, b.s_min, b.v_min, b.v_max});
    end
    tests_run++;
    if ({b.thr_valid, b.active_id, b.result_valid, b.result_id, b.result_count} !== 25'd0) begin
      fails++; $display("FAIL rst_drain_ctrl: got tv=%b aid=%0d rv=%b id=%0d cnt=%0d expected all 0", b.thr_valid, b.active_id, b.result_valid, b.result_id, b.result_count);
    end
    tick;
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (b.result_valid || b.thr_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      fails++; $display("FAIL rst_drain_quiet: got %0d active cycles expected 0", seen);
    end
    b.frame_start = 1;
    tick;
    b.frame_start = 0;
    tick;
    tests_run++;
    if ({b.thr_valid, b.active_id, b.h_min, b.s_min} !== {1'b1, 2'd0, 8'd0, 8'd151}) begin
      fails++; $display("FAIL rst_restart: got tv=%b aid=%0d h_min=%0d s_min=%0d expected 1 0 0 151", b.thr_valid, b.active_id, b.h_min, b.s_min);
    end
    do_frame(0, got, rid, rcnt, raid, rsmin);
    tests_run++;
    if ({got, rid, raid} !== {1'b1, 2'd0, 2'd0}) begin
      fails++; $display("FAIL rst_shadow_en: got v=%b id=%0d aid=%0d expected 1 0 0", got, rid, raid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_first_frame;
    test_single_profile;
    test_round_robin;
    test_switch_write;
    test_saturate;
    test_drain_fs;
    test_reset_drain;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
